// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// key_debouncer_pkg
// Shared constants for the push-button conditioning logic.
//   CLK_FREQ_HZ          : board clock frequency.
//   DEBOUNCE_CYCLES_20MS : clock cycles in 20 ms at CLK_FREQ_HZ.
//   DEBOUNCE_CNT_W       : counter width able to hold DEBOUNCE_CYCLES_20MS-1.
// -----------------------------------------------------------------------------
package key_debouncer_pkg;

  localparam int unsigned CLK_FREQ_HZ          = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_20MS = 1_000_000;
  localparam int unsigned DEBOUNCE_CNT_W       = 20;

endpackage : key_debouncer_pkg

// File: rtl/key_debounce_bit.sv
// -----------------------------------------------------------------------------
// key_debounce_bit
// One push-button channel: two-flop synchronizer, stability counter and
// press/release pulse generation.
// Ports:
//   i_clk      : system clock
//   i_reset_n  : synchronous, active-low reset
//   i_key_n    : raw button, active-low, asynchronous to i_clk
//   o_down     : debounced level, 1 = held
//   o_press    : one-cycle pulse when a press is accepted
//   o_release  : one-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module key_debounce_bit
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_20MS,
  parameter int CNT_W         = DEBOUNCE_CNT_W
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_key_n,
  output logic o_down,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_down;
  logic             r_press;
  logic             r_release;

  logic             w_raw;
  logic             w_mismatch;
  logic             w_expire;

  assign w_raw      = ~r_s2;
  assign w_mismatch = (w_raw != r_down);
  // The counter stops at LP_LAST: reaching it on a mismatch flips the level.
  assign w_expire   = w_mismatch && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      // Sync stages reset to "released" so a held key is re-debounced.
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_cnt     <= '0;
      r_down    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_key_n;
      r_s2      <= r_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_cnt     <= '0;
        r_down    <= w_raw;
        r_press   <= w_raw;
        r_release <= ~w_raw;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_down    = r_down;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule : key_debounce_bit

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Conditions W asynchronous active-low push-buttons into clean active-high
// levels plus one-cycle press/release pulses. Every key is independent.
// Ports:
//   i_clk      : system clock (50 MHz on board)
//   i_reset_n  : synchronous, active-low reset
//   i_key_n    : [W-1:0] raw buttons, active-low, asynchronous
//   o_down     : [W-1:0] debounced level, 1 = key held
//   o_press    : [W-1:0] one-cycle pulse on accepted press
//   o_release  : [W-1:0] one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int W             = 2,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_20MS,
  parameter int CNT_W         = DEBOUNCE_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_key_n,
  output logic [W-1:0] o_down,
  output logic [W-1:0] o_press,
  output logic [W-1:0] o_release
);

  for (genvar gi = 0; gi < W; gi++) begin : g_key
    key_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_key_n   (i_key_n[gi]),
      .o_down    (o_down[gi]),
      .o_press   (o_press[gi]),
      .o_release (o_release[gi])
    );
  end

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_n;
  logic [1:0] down, press, rel;

  // Second instance for the STABLE_CYCLES=1 boundary.
  logic       reset1_n;
  logic [0:0] key1_n;
  logic [0:0] down1, press1, rel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_debouncer #(.W(2), .STABLE_CYCLES(4), .CNT_W(3)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_key_n   (key_n),
    .o_down    (down),
    .o_press   (press),
    .o_release (rel)
  );

  key_debouncer #(.W(1), .STABLE_CYCLES(1), .CNT_W(1)) dut1 (
    .i_clk     (clk),
    .i_reset_n (reset1_n),
    .i_key_n   (key1_n),
    .o_down    (down1),
    .o_press   (press1),
    .o_release (rel1)
  );

  // From edge 'edge_n' on, inputs are key_n/reset_n; outputs observed right
  // after that edge are down/press/rel. Pulses last only for that edge.
  typedef struct {
    int         edge_n;
    logic [1:0] key_n;
    logic       reset_n;
    logic [1:0] down;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  typedef struct {
    int         edge_n;
    logic [1:0] down;
    logic [1:0] press;
    logic [1:0] rel;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int n, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: actual=%b required=%b", name, n, act, req);
    end
  endtask

  initial begin
    vec_t vec[15];
    logic [1:0] cur_key;
    logic       cur_rst;
    logic [1:0] cur_down;
    exp_t       e;
    exp_t       got;

    vec = '{
      '{ 1, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00},  // reset edges 1-3
      '{ 4, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00},
      '{10, 2'b10, 1'b1, 2'b00, 2'b00, 2'b00},  // key0 pressed
      '{15, 2'b10, 1'b1, 2'b01, 2'b01, 2'b00},
      '{20, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00},  // key1 glitch, 3 cycles
      '{23, 2'b10, 1'b1, 2'b01, 2'b00, 2'b00},
      '{26, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00},  // bounce 0,1,0,0,1
      '{27, 2'b10, 1'b1, 2'b01, 2'b00, 2'b00},
      '{28, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00},
      '{30, 2'b10, 1'b1, 2'b01, 2'b00, 2'b00},
      '{40, 2'b11, 1'b1, 2'b01, 2'b00, 2'b00},  // key0 released
      '{45, 2'b11, 1'b1, 2'b00, 2'b00, 2'b01},
      '{60, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00},  // both pressed
      '{65, 2'b00, 1'b1, 2'b11, 2'b11, 2'b00},
      '{80, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00}   // reset while held
    };

    cur_key  = 2'b11;
    cur_rst  = 1'b0;
    cur_down = 2'b00;
    reset1_n = 1'b0;
    key1_n   = 1'b1;

    for (int n = 1; n <= 95; n++) begin
      e.edge_n = n;
      e.press  = 2'b00;
      e.rel    = 2'b00;
      foreach (vec[k]) begin
        if (vec[k].edge_n == n) begin
          cur_key  = vec[k].key_n;
          cur_rst  = vec[k].reset_n;
          cur_down = vec[k].down;
          e.press  = vec[k].press;
          e.rel    = vec[k].rel;
        end
      end
      // Reset released at edge 81; held keys re-accepted 5 edges later.
      if (n == 81) cur_rst = 1'b1;
      if (n == 86) begin
        cur_down = 2'b11;
        e.press  = 2'b11;
      end
      e.down  = cur_down;
      key_n   = cur_key;
      reset_n = cur_rst;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = sb.pop_front();
      chk("down",    got.edge_n, down,  got.down);
      chk("press",   got.edge_n, press, got.press);
      chk("release", got.edge_n, rel,   got.rel);
    end

    // STABLE_CYCLES=1: toggle two edges after the key level is first sampled.
    for (int j = 1; j <= 12; j++) begin
      logic [1:0] ed, ep, er;
      reset1_n = 1'b1;
      key1_n   = (j >= 3 && j <= 7) ? 1'b0 : 1'b1;
      ed = {1'b0, (j >= 5 && j < 10)};
      ep = {1'b0, (j == 5)};
      er = {1'b0, (j == 10)};
      @(posedge clk);
      @(negedge clk);
      chk("s1_down",    j, {1'b0, down1},  ed);
      chk("s1_press",   j, {1'b0, press1}, ep);
      chk("s1_release", j, {1'b0, rel1},   er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_debouncer
